// File: rtl/serial_word_rx_if.sv
// serial_word_rx_if: serial line plus word handshake bundle
// master drives the line and ready, slave is the receiver
interface serial_word_rx_if #(
  parameter int NUM_BITS = 32
);
  logic                bit_strobe;
  logic                serial_in;
  logic                data_ready;
  logic [NUM_BITS-1:0] rx_data;
  logic                data_valid;
  logic                framing_error;
  logic                overrun_error;
  logic                busy;

  modport master (
    output bit_strobe,
    output serial_in,
    output data_ready,
    input  rx_data,
    input  data_valid,
    input  framing_error,
    input  overrun_error,
    input  busy
  );

  modport slave (
    input  bit_strobe,
    input  serial_in,
    input  data_ready,
    output rx_data,
    output data_valid,
    output framing_error,
    output overrun_error,
    output busy
  );
endinterface

// File: rtl/serial_word_rx.sv
// serial_word_rx: idle-high serial frame receiver
// start/data/stop framing, valid/ready word output
module serial_word_rx #(
  parameter int NUM_BITS  = 32,
  parameter bit SHIFT_MSB = 1'b1
) (
  input logic          clk,
  input logic          n_rst,
  serial_word_rx_if.slave bus
);

  localparam int CW = $clog2(NUM_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [NUM_BITS-1:0] shreg;
  logic [NUM_BITS-1:0] shreg_next;
  logic [NUM_BITS-1:0] rx_data;
  logic                data_valid;
  logic                framing_error;
  logic                overrun_error;
  logic                busy;
  logic                consume;
  logic                room;

  assign consume = data_valid & bus.data_ready;
  assign room    = ~data_valid | bus.data_ready;

  // next shift register value for the incoming data bit
  always_comb begin
    shreg_next = shreg;
    if (SHIFT_MSB)
      shreg_next = {shreg[NUM_BITS-2:0], bus.serial_in};
    else
      shreg_next = {bus.serial_in, shreg[NUM_BITS-1:1]};
  end

  // frame FSM, shift register and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      shreg         <= '1;
      rx_data       <= '1;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      if (consume)
        data_valid <= 1'b0;
      if (bus.bit_strobe) begin
        unique case (state)
          IDLE: begin
            if (!bus.serial_in) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            shreg <= shreg_next;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(NUM_BITS - 1))
              state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!bus.serial_in)
              framing_error <= 1'b1;
            else if (room) begin
              rx_data    <= shreg;
              data_valid <= 1'b1;
            end else
              overrun_error <= 1'b1;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data       = rx_data;
  assign bus.data_valid    = data_valid;
  assign bus.framing_error = framing_error;
  assign bus.overrun_error = overrun_error;
  assign bus.busy          = busy;

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: random and directed frames into
// MSB-first and LSB-first receivers vs a word-level model
module tb_serial_word_rx;

  logic clk;
  logic n_rst;
  logic strobe;
  logic sin;
  logic rdy;

  int total;
  int bad;

  logic [7:0] m_msb;
  logic [7:0] m_lsb;
  logic       m_valid;
  logic       m_fe;
  logic       m_oe;

  serial_word_rx_if #(.NUM_BITS(8)) bm ();
  serial_word_rx_if #(.NUM_BITS(8)) bl ();

  assign bm.bit_strobe = strobe;
  assign bm.serial_in  = sin;
  assign bm.data_ready = rdy;
  assign bl.bit_strobe = strobe;
  assign bl.serial_in  = sin;
  assign bl.data_ready = rdy;

  serial_word_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) u_msb (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bm.slave)
  );

  serial_word_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) u_lsb (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bl.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rev(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  // one clock: word-level model update, then advance past the edge
  task automatic step(input logic is_stop, input logic sv,
                      input logic [7:0] d);
    logic load;
    load = 1'b0;
    m_fe = 1'b0;
    m_oe = 1'b0;
    if (is_stop && strobe) begin
      if (!sv) m_fe = 1'b1;
      else if (!m_valid || rdy) begin
        m_msb = d;
        m_lsb = rev(d);
        load  = 1'b1;
      end else m_oe = 1'b1;
    end
    if (load) m_valid = 1'b1;
    else if (m_valid && rdy) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // start, d[7] first .. d[0], stop; returns just after stop edge
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int gap, input logic rs);
    logic keep;
    keep = rdy;
    strobe = 1'b1; sin = 1'b0; step(1'b0, 1'b0, 8'h00);
    strobe = 1'b0; sin = 1'b1;
    repeat (gap) step(1'b0, 1'b0, 8'h00);
    for (int i = 7; i >= 0; i--) begin
      strobe = 1'b1; sin = d[i]; step(1'b0, 1'b0, 8'h00);
      strobe = 1'b0;
      repeat (gap) step(1'b0, 1'b0, 8'h00);
    end
    strobe = 1'b1; sin = stop;
    if (rs) rdy = 1'b1;
    step(1'b1, stop, d);
    strobe = 1'b0; sin = 1'b1; rdy = keep;
  endtask

  task automatic do_reset();
    #3 n_rst = 1'b0;
    m_valid = 1'b0;
    m_msb = 8'hFF;
    m_lsb = 8'hFF;
    m_fe = 1'b0;
    m_oe = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    strobe = 1'b0; sin = 1'b1; rdy = 1'b0; n_rst = 1'b1;
    @(posedge clk); #1;
    do_reset();
    total++;
    if (bm.rx_data !== 8'hFF) begin
      bad++; $display("FAIL reset_msb_data got %h want ff", bm.rx_data);
    end
    total++;
    if (bl.rx_data !== 8'hFF) begin
      bad++; $display("FAIL reset_lsb_data got %h want ff", bl.rx_data);
    end
    total++;
    if ({bm.data_valid, bm.busy, bm.framing_error, bm.overrun_error}
        !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got %b%b%b%b want 0000", bm.data_valid,
               bm.busy, bm.framing_error, bm.overrun_error);
    end
    release_reset();
  endtask

  task automatic test_msb_b2b();
    rdy = 1'b0;
    send_frame(8'hC1, 1'b1, 0, 1'b0);
    total++;
    if (bm.rx_data !== 8'hC1 || bm.data_valid !== 1'b1) begin
      bad++;
      $display("FAIL msb_frame got %h/%b want c1/1", bm.rx_data,
               bm.data_valid);
    end
    total++;
    if (bl.rx_data !== 8'h83) begin
      bad++; $display("FAIL lsb_frame_b2b got %h want 83", bl.rx_data);
    end
    repeat (3) step(1'b0, 1'b0, 8'h00);
    total++;
    if (bm.data_valid !== 1'b1) begin
      bad++; $display("FAIL msb_hold got %b want 1", bm.data_valid);
    end
    rdy = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    rdy = 1'b0;
    total++;
    if (bm.data_valid !== 1'b0 || bl.data_valid !== 1'b0) begin
      bad++;
      $display("FAIL consume got %b%b want 00", bm.data_valid,
               bl.data_valid);
    end
  endtask

  task automatic test_lsb_spaced();
    for (int i = 0; i < 3; i++) begin
      strobe = 1'b1; sin = 1'b1; step(1'b0, 1'b0, 8'h00);
      strobe = 1'b0;
      repeat (2) step(1'b0, 1'b0, 8'h00);
      total++;
      if (bl.busy !== 1'b0) begin
        bad++; $display("FAIL idle_busy got %b want 0", bl.busy);
      end
    end
    send_frame(8'hC1, 1'b1, 2, 1'b0);
    total++;
    if (bl.rx_data !== 8'h83 || bl.data_valid !== 1'b1) begin
      bad++;
      $display("FAIL lsb_spaced got %h/%b want 83/1", bl.rx_data,
               bl.data_valid);
    end
    rdy = 1'b1; step(1'b0, 1'b0, 8'h00); rdy = 1'b0;
  endtask

  task automatic test_framing();
    do_reset();
    release_reset();
    send_frame(8'hA5, 1'b0, 0, 1'b0);
    total++;
    if (bm.framing_error !== 1'b1 || bl.framing_error !== 1'b1) begin
      bad++;
      $display("FAIL fe_pulse got %b%b want 11", bm.framing_error,
               bl.framing_error);
    end
    total++;
    if (bm.data_valid !== 1'b0 || bm.rx_data !== 8'hFF ||
        bm.busy !== 1'b0) begin
      bad++;
      $display("FAIL fe_state got %b/%h/%b want 0/ff/0", bm.data_valid,
               bm.rx_data, bm.busy);
    end
    step(1'b0, 1'b0, 8'h00);
    total++;
    if (bm.framing_error !== 1'b0) begin
      bad++; $display("FAIL fe_width got %b want 0", bm.framing_error);
    end
  endtask

  task automatic test_overrun();
    rdy = 1'b0;
    send_frame(8'h11, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b1, 0, 1'b0);
    total++;
    if (bm.overrun_error !== 1'b1 || bm.rx_data !== 8'h11 ||
        bm.data_valid !== 1'b1) begin
      bad++;
      $display("FAIL overrun got %b/%h/%b want 1/11/1", bm.overrun_error,
               bm.rx_data, bm.data_valid);
    end
    step(1'b0, 1'b0, 8'h00);
    total++;
    if (bm.overrun_error !== 1'b0) begin
      bad++; $display("FAIL oe_width got %b want 0", bm.overrun_error);
    end
    rdy = 1'b1; step(1'b0, 1'b0, 8'h00); rdy = 1'b0;
    send_frame(8'h11, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b1, 0, 1'b1);
    total++;
    if (bm.overrun_error !== 1'b0 || bm.rx_data !== 8'h22 ||
        bm.data_valid !== 1'b1) begin
      bad++;
      $display("FAIL no_overrun got %b/%h/%b want 0/22/1",
               bm.overrun_error, bm.rx_data, bm.data_valid);
    end
    total++;
    if (bl.rx_data !== 8'h44) begin
      bad++; $display("FAIL no_overrun_lsb got %h want 44", bl.rx_data);
    end
    rdy = 1'b1; step(1'b0, 1'b0, 8'h00); rdy = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'hC3;
    strobe = 1'b1; sin = 1'b0; step(1'b0, 1'b0, 8'h00);
    for (int i = 7; i >= 4; i--) begin
      sin = d[i]; step(1'b0, 1'b0, 8'h00);
    end
    strobe = 1'b0;
    total++;
    if (bm.busy !== 1'b1) begin
      bad++; $display("FAIL mid_busy got %b want 1", bm.busy);
    end
    do_reset();
    total++;
    if (bm.busy !== 1'b0 || bm.rx_data !== 8'hFF ||
        bm.data_valid !== 1'b0 || bm.framing_error !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got %b/%h/%b/%b want 0/ff/0/0", bm.busy,
               bm.rx_data, bm.data_valid, bm.framing_error);
    end
    release_reset();
    send_frame(8'h5A, 1'b1, 0, 1'b0);
    total++;
    if (bm.rx_data !== 8'h5A || bm.data_valid !== 1'b1) begin
      bad++;
      $display("FAIL after_reset got %h/%b want 5a/1", bm.rx_data,
               bm.data_valid);
    end
    rdy = 1'b1; step(1'b0, 1'b0, 8'h00); rdy = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    int         gap;
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = int'($urandom_range(0, 3));
      rdy  = ($urandom_range(0, 2) == 0);
      send_frame(d, stop, gap, 1'($urandom_range(0, 1)));
      total++;
      if (bm.rx_data !== m_msb || bl.rx_data !== m_lsb ||
          bm.data_valid !== m_valid || bl.data_valid !== m_valid) begin
        bad++;
        $display("FAIL rand_word n=%0d got %h/%h/%b want %h/%h/%b", n,
                 bm.rx_data, bl.rx_data, bm.data_valid, m_msb, m_lsb,
                 m_valid);
      end
      total++;
      if (bm.framing_error !== m_fe || bm.overrun_error !== m_oe ||
          bl.framing_error !== m_fe || bl.overrun_error !== m_oe ||
          bm.busy !== 1'b0) begin
        bad++;
        $display("FAIL rand_flags n=%0d got %b%b%b want %b%b0", n,
                 bm.framing_error, bm.overrun_error, bm.busy, m_fe, m_oe);
      end
      rdy = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'h00);
      rdy = 1'b0;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_valid = 1'b0;
    m_msb = 8'hFF;
    m_lsb = 8'hFF;
    m_fe = 1'b0;
    m_oe = 1'b0;
    test_reset();
    test_msb_b2b();
    test_lsb_spaced();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel frame receiver: the receiving end of the idle-high serial link driven by the team's parallel-to-serial transmitter. It detects a start bit, shifts in NUM_BITS data bits on a bit strobe, checks the stop bit, and presents the assembled word to the downstream FFT input logic with a valid/ready handshake. It flags framing and overrun errors.

## Interface
- NUM_BITS, 32, data bits per frame (>= 2)
- SHIFT_MSB, 1, 1: first data bit received lands in rx_data[NUM_BITS-1]; 0: first data bit lands in rx_data[0]
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- bit_strobe  in  1  serial_in is sampled only on cycles where this is 1
- serial_in  in  1  serial line, idle high
- data_ready  in  1  consumer accepts rx_data this cycle
- rx_data  out  NUM_BITS  last accepted word
- data_valid  out  1  rx_data holds an unconsumed word
- framing_error  out  1  one-cycle pulse: stop bit was 0
- overrun_error  out  1  one-cycle pulse: good frame arrived while previous word unconsumed
- busy  out  1  frame in progress (state != IDLE)

## Operation
- Frame: start bit 0, NUM_BITS data bits, stop bit 1; one bit per bit_strobe.
- FSM states IDLE, DATA, STOP. Cycles with bit_strobe=0 change no FSM, counter or shift-register state.
- IDLE: strobe with serial_in=0 -> DATA, bit counter cleared. Strobe with serial_in=1 -> stay IDLE.
- DATA: each strobe shifts serial_in into the internal shift register and increments the counter.
  - SHIFT_MSB=1: shift left, new bit into bit 0.
  - SHIFT_MSB=0: shift right, new bit into bit NUM_BITS-1.
  - On the strobe carrying data bit NUM_BITS -> STOP.
- Bit counter width is $clog2(NUM_BITS+1). The counter never wraps within a frame.
- STOP, on strobe, always -> IDLE:
  - serial_in=1 and (data_valid=0 or data_ready=1): rx_data <= shift register; data_valid <= 1.
  - serial_in=1, data_valid=1 and data_ready=0: new word dropped; rx_data and data_valid unchanged; overrun_error pulses.
  - serial_in=0: word discarded; framing_error pulses. If the line is still 0 at the next strobe, that strobe is a new start bit.
- Handshake:
  - data_valid=1 and data_ready=1 at a clock edge consumes the word; data_valid is 0 the next cycle unless a good stop bit is accepted at the same edge, in which case it stays 1 with the new word.
  - data_ready while data_valid=0 is ignored.
- rx_data changes only when a good frame is loaded.
- busy = 1 in DATA and STOP.

## Timing
- Reset values (async, immediate):
  - rx_data all 1s; internal shift register all 1s.
  - data_valid 0, framing_error 0, overrun_error 0, busy 0.
  - State IDLE, counter 0.
- Reset mid-frame aborts the frame with no error pulse.
- Latency: rx_data and data_valid update at the clock edge that samples the good stop bit, visible the following cycle.
- Error pulses are registered, high for exactly one cycle after the stop-bit edge.
- busy rises the cycle after the start-bit edge and falls the cycle after the stop-bit edge.
- Minimum frame time: NUM_BITS+2 strobes. Strobes may be back-to-back every cycle or arbitrarily spaced.

## Test plan
Bench uses NUM_BITS=8.
- Reset: assert n_rst=0 mid-cycle -> rx_data=0xFF, data_valid=0, busy=0, both error flags 0, immediately.
- SHIFT_MSB=1, strobes every cycle: start 0, data 1,1,0,0,0,0,0,1, stop 1 -> rx_data=0xC1, data_valid=1 the cycle after the stop edge, held until data_ready=1, then 0 the next cycle.
- SHIFT_MSB=0, same frame with strobes every 3rd cycle -> rx_data=0x83. Idle strobes with serial_in=1 before the start bit leave busy=0.
- Framing error: frame with data 0xA5 and stop 0 -> framing_error is a one-cycle pulse, data_valid stays 0, rx_data stays 0xFF, FSM returns to IDLE.
- Overrun:
  - Two good frames 0x11 then 0x22 with data_ready=0 -> overrun_error pulses once at the second stop; rx_data=0x11.
  - Repeat with data_ready=1 on the second stop edge -> no overrun; rx_data=0x22; data_valid stays 1.
- Reset mid-frame after 4 data bits -> reset values, busy=0. The next full frame carrying 0x5A (SHIFT_MSB=1) is received correctly.
